systolic_pe_tile: RTL and testbench
===================================

Name: systolic_pe_tile

Overview:
- Next-generation weight/activation MAC processing element for the systolic array.
- Forwards operands with valid and last tags and supports signed or unsigned operands.
- Optional multiply pipeline stage; accumulator saturates instead of wrapping.
- On the last beat of a tile, captures the result into a per-column drain shift chain and auto-clears, so tiles run back-to-back with no clear bubble.

Parameters:
- DATA_W, 16: operand width. Constraint: ACC_W >= 2*DATA_W.
- ACC_W, 32: accumulator and result width.
- MUL_PIPE, 1: 0 means product is combinational into the accumulate stage; 1 means one registered product stage.
- SATURATE, 1: 1 clamps the accumulator to range; 0 wraps modulo 2^ACC_W.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- en in 1: global advance. 0 freezes every register, including the drain chain.
- clear_acc in 1: synchronous clear of the accumulator, the in-flight product and ovf.
- signed_mode in 1: 1 means two's-complement operands; 0 means unsigned. Sampled with the operands.
- a_in in DATA_W: west operand.
- a_valid_in in 1: west operand valid.
- a_last_in in 1: final k-beat of the tile, travels with a.
- b_in in DATA_W: north operand.
- b_valid_in in 1: north operand valid.
- a_out, a_valid_out, a_last_out out DATA_W/1/1: east forward.
- b_out, b_valid_out out DATA_W/1: south forward.
- drain_in in ACC_W: result from the PE above.
- drain_valid_in in 1: drain_in valid.
- drain_shift in 1: shift the drain chain by one this cycle.
- drain_out out ACC_W: result toward the PE below.
- drain_valid_out out 1: drain_out valid.
- acc_out out ACC_W: live accumulator.
- ovf out 1: sticky saturation/overflow flag.
- drain_err out 1: sticky flag for a result lost to a drain collision.

Behaviour:
- Reset: all registered outputs, the accumulator and the pipeline registers go to 0 asynchronously on rst_n low.
  - Reset mid-tile discards all partial state.
- Forwarding: when en=1, {a,a_valid,a_last} and {b,b_valid} are registered to the outputs unconditionally, 1-cycle latency. When en=0 they hold.
- Fire condition: fire = en & a_valid_in & b_valid_in.
  - One-sided valid: the operand is forwarded, no accumulate.
- Product formation:
  - Signed mode: each operand is sign-extended to DATA_W+1 bits.
  - Unsigned mode: each operand is zero-extended to DATA_W+1 bits.
  - The product is sign-extended to ACC_W+2 bits.
  - With MUL_PIPE=1, the product, fire, last and mode are registered one stage.
- Accumulate stage: sum = acc + prod, computed at ACC_W+2 bits.
  - Signed range: [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned range: [0, 2^ACC_W-1]; acc_out carries the raw ACC_W bits.
  - Out of range with SATURATE=1: clamp to the nearer bound and set ovf.
  - Out of range with SATURATE=0: truncate and set ovf.
- Latency: an operand pair presented at cycle t affects acc_out at t+1+MUL_PIPE.
- Last beat reaching the accumulate stage:
  - drain_out <= sat(sum); drain_valid_out <= 1; acc <= 0 (not sum).
  - The next tile's first beat may follow in the very next cycle.
- Drain chain: when en & drain_shift and no capture this cycle, drain_out <= drain_in and drain_valid_out <= drain_valid_in.
- Capture/shift collision: capture wins.
  - If drain_valid_in=1 in that cycle, upstream data is dropped and drain_err is set.
  - Capture when drain_valid_out=1 and drain_shift=0 overwrites the old result and sets drain_err.
- clear_acc (with en=1):
  - Zeroes acc, zeroes the in-flight product valid, zeroes ovf.
  - Discards operands firing that cycle.
  - Clear has priority over fire and capture.
  - Does not touch the drain chain or drain_err; drain_err clears only on reset.
- signed_mode must be constant for a tile. A mid-tile change applies per beat and is not an error.

Decomposition:
- Package systolic_pkg holds:
  - pe_mode_e (MODE_UNSIGNED=0, MODE_SIGNED=1).
  - sat_bounds function (ACC_W, mode) returning min/max.
  - Localparam PROD_W = ACC_W+2.
- One sub-module, systolic_sat_acc: combinational add + clamp + overflow detect, reused by the future output requantiser.
- Pipeline and drain registers stay in the top module.

Test Plan:
- Signed dot product, MUL_PIPE=1: a={3,-2,5}, b={4,7,-1} all valid, last on the third beat.
  - Required: drain_out=-7 with drain_valid_out=1 at t+1+1 after the last beat.
  - Required: acc_out=0 the next cycle; a_out lags a_in by exactly 1 cycle.
- Unsigned vs signed, DATA_W=16: a=0xFFFF, b=0x0002, one beat with last.
  - Required: unsigned mode gives 0x0001FFFE; signed mode gives 0xFFFFFFFE (-2).
- Saturation, signed, SATURATE=1: preload via 0x7FFF*0x7FFF beats, repeated 3 times.
  - Required: acc clamps at 0x7FFFFFFF and ovf=1.
  - Required: clear_acc then gives acc_out=0 and ovf=0.
- Back-to-back tiles: tile1 a=b={1,1} last; tile2 a=b={2,2} last, with no gap.
  - Required: results 2 then 8; no contamination between tiles.
- Drain collision: drain_valid_out=1, drain_shift=1, drain_valid_in=1 in the same cycle as a capture of result 5.
  - Required: drain_out=5 and drain_err=1.
  - Required: with drain_valid_in=0 instead, drain_err stays 0.
- Control corners:
  - en=0 for 3 cycles mid-tile: all outputs hold and the final result is unchanged.
  - rst_n pulsed low mid-tile: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic PE tile and its saturating accumulator.
package systolic_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } pe_mode_e;

    localparam int ACC_W_DEF = 32;
    localparam int PROD_W    = ACC_W_DEF + 2;

    typedef struct packed {
        logic signed [63:0] lo;
        logic signed [63:0] hi;
    } sat_bounds_t;

    // Representable accumulator range for the given width and operand mode.
    function automatic sat_bounds_t sat_bounds(input int acc_w, input pe_mode_e mode);
        sat_bounds_t b;
        if (mode == MODE_SIGNED) begin
            b.hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
            b.lo = -(64'sd1 <<< (acc_w - 1));
        end else begin
            b.lo = 64'sd0;
            b.hi = (64'sd1 <<< acc_w) - 64'sd1;
        end
        return b;
    endfunction

endpackage

// File: rtl/systolic_sat_acc.sv
// Combinational accumulate: acc + prod at ACC_W+2 bits, range check, clamp or wrap.
module systolic_sat_acc
    import systolic_pkg::*;
#(
    parameter int ACC_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0]        i_acc,
    input  logic signed [ACC_W+1:0] i_prod,
    input  pe_mode_e                i_mode,
    output logic [ACC_W-1:0]        o_result,
    output logic                    o_ovf
);

    localparam int SUM_W = ACC_W + 2;
    localparam sat_bounds_t S_BOUNDS = sat_bounds(ACC_W, MODE_SIGNED);
    localparam sat_bounds_t U_BOUNDS = sat_bounds(ACC_W, MODE_UNSIGNED);

    logic signed [SUM_W-1:0] w_acc_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_lo;
    logic signed [SUM_W-1:0] w_hi;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_result = '0;
        o_ovf    = 1'b0;
        if (i_mode == MODE_SIGNED) begin
            w_acc_ext = {{2{i_acc[ACC_W-1]}}, i_acc};
            w_lo      = S_BOUNDS.lo[SUM_W-1:0];
            w_hi      = S_BOUNDS.hi[SUM_W-1:0];
        end else begin
            w_acc_ext = {2'b00, i_acc};
            w_lo      = U_BOUNDS.lo[SUM_W-1:0];
            w_hi      = U_BOUNDS.hi[SUM_W-1:0];
        end
        w_sum    = w_acc_ext + i_prod;
        o_result = w_sum[ACC_W-1:0];
        if (w_sum < w_lo) begin
            o_ovf = 1'b1;
            if (SATURATE != 0) o_result = w_lo[ACC_W-1:0];
        end else if (w_sum > w_hi) begin
            o_ovf = 1'b1;
            if (SATURATE != 0) o_result = w_hi[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/systolic_pe_tile.sv
// Weight/activation MAC PE: operand forwarding, optional product stage,
// saturating accumulator with auto-clear on last beat and a per-column drain chain.
module systolic_pe_tile
    import systolic_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int MUL_PIPE = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear_acc,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic              a_last_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic              a_last_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic [ACC_W-1:0]  drain_in,
    input  logic              drain_valid_in,
    input  logic              drain_shift,
    output logic [ACC_W-1:0]  drain_out,
    output logic              drain_valid_out,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              drain_err
);

    localparam int SUM_W = ACC_W + 2;

    logic signed [DATA_W:0]     w_a_ext;
    logic signed [DATA_W:0]     w_b_ext;
    logic signed [2*DATA_W+1:0] w_mul;
    logic signed [SUM_W-1:0]    w_prod;
    logic                       w_fire;

    logic signed [SUM_W-1:0]    w_s_prod;
    logic                       w_s_fire;
    logic                       w_s_last;
    pe_mode_e                   w_s_mode;

    logic [ACC_W-1:0]           w_sum_sat;
    logic                       w_sum_ovf;
    logic                       w_capture;

    logic [DATA_W-1:0]          r_a;
    logic                       r_a_valid;
    logic                       r_a_last;
    logic [DATA_W-1:0]          r_b;
    logic                       r_b_valid;
    logic [ACC_W-1:0]           r_acc;
    logic                       r_ovf;
    logic [ACC_W-1:0]           r_drain;
    logic                       r_drain_valid;
    logic                       r_drain_err;

    assign w_fire  = en & a_valid_in & b_valid_in;
    assign w_a_ext = signed_mode ? {a_in[DATA_W-1], a_in} : {1'b0, a_in};
    assign w_b_ext = signed_mode ? {b_in[DATA_W-1], b_in} : {1'b0, b_in};
    assign w_mul   = w_a_ext * w_b_ext;
    assign w_prod  = SUM_W'(w_mul);

    generate
        if (MUL_PIPE != 0) begin : g_pipe
            logic signed [SUM_W-1:0] r_p_prod;
            logic                    r_p_fire;
            logic                    r_p_last;
            pe_mode_e                r_p_mode;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_p_prod <= '0;
                    r_p_fire <= 1'b0;
                    r_p_last <= 1'b0;
                    r_p_mode <= MODE_UNSIGNED;
                end else if (en) begin
                    // A clear drops the beat firing alongside it before it lands here.
                    r_p_prod <= w_prod;
                    r_p_fire <= w_fire & ~clear_acc;
                    r_p_last <= a_last_in;
                    r_p_mode <= pe_mode_e'(signed_mode);
                end
            end

            assign w_s_prod = r_p_prod;
            assign w_s_fire = r_p_fire;
            assign w_s_last = r_p_last;
            assign w_s_mode = r_p_mode;
        end else begin : g_comb
            assign w_s_prod = w_prod;
            assign w_s_fire = w_fire & ~clear_acc;
            assign w_s_last = a_last_in;
            assign w_s_mode = pe_mode_e'(signed_mode);
        end
    endgenerate

    systolic_sat_acc #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_acc (
        .i_acc    (r_acc),
        .i_prod   (w_s_prod),
        .i_mode   (w_s_mode),
        .o_result (w_sum_sat),
        .o_ovf    (w_sum_ovf)
    );

    assign w_capture = w_s_fire & w_s_last & ~clear_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
            r_b       <= '0;
            r_b_valid <= 1'b0;
        end else if (en) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            r_a       <= a_in;
            r_a_valid <= a_valid_in;
            r_a_last  <= a_last_in;
            r_b       <= b_in;
            r_b_valid <= b_valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            r_ovf         <= 1'b0;
            r_drain       <= '0;
            r_drain_valid <= 1'b0;
            r_drain_err   <= 1'b0;
        end else if (en) begin
            if (clear_acc) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_s_fire) begin
                r_acc <= w_s_last ? '0 : w_sum_sat;
                if (w_sum_ovf) r_ovf <= 1'b1;
            end

            // Capture beats a shift; whichever result it displaces is flagged.
            if (w_capture) begin
                r_drain       <= w_sum_sat;
                r_drain_valid <= 1'b1;
                if ((drain_shift && drain_valid_in) || (!drain_shift && r_drain_valid))
                    r_drain_err <= 1'b1;
            end else if (drain_shift) begin
                r_drain       <= drain_in;
                r_drain_valid <= drain_valid_in;
            end
        end
    end

    assign a_out           = r_a;
    assign a_valid_out     = r_a_valid;
    assign a_last_out      = r_a_last;
    assign b_out           = r_b;
    assign b_valid_out     = r_b_valid;
    assign acc_out         = r_acc;
    assign ovf             = r_ovf;
    assign drain_out       = r_drain;
    assign drain_valid_out = r_drain_valid;
    assign drain_err       = r_drain_err;

endmodule

// File: tb/tb_systolic_pe_tile.sv
// Directed bench for systolic_pe_tile (DATA_W=16, ACC_W=32, MUL_PIPE=1, SATURATE=1).
module tb_systolic_pe_tile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clear_acc;
    logic        signed_mode;
    logic [15:0] a_in;
    logic        a_valid_in;
    logic        a_last_in;
    logic [15:0] b_in;
    logic        b_valid_in;
    logic [15:0] a_out;
    logic        a_valid_out;
    logic        a_last_out;
    logic [15:0] b_out;
    logic        b_valid_out;
    logic [31:0] drain_in;
    logic        drain_valid_in;
    logic        drain_shift;
    logic [31:0] drain_out;
    logic        drain_valid_out;
    logic [31:0] acc_out;
    logic        ovf;
    logic        drain_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    systolic_pe_tile #(
        .DATA_W   (16),
        .ACC_W    (32),
        .MUL_PIPE (1),
        .SATURATE (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .clear_acc       (clear_acc),
        .signed_mode     (signed_mode),
        .a_in            (a_in),
        .a_valid_in      (a_valid_in),
        .a_last_in       (a_last_in),
        .b_in            (b_in),
        .b_valid_in      (b_valid_in),
        .a_out           (a_out),
        .a_valid_out     (a_valid_out),
        .a_last_out      (a_last_out),
        .b_out           (b_out),
        .b_valid_out     (b_valid_out),
        .drain_in        (drain_in),
        .drain_valid_in  (drain_valid_in),
        .drain_shift     (drain_shift),
        .drain_out       (drain_out),
        .drain_valid_out (drain_valid_out),
        .acc_out         (acc_out),
        .ovf             (ovf),
        .drain_err       (drain_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        a_valid_in = 1'b0;
        b_valid_in = 1'b0;
        a_last_in  = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last,
                        input logic sm);
        a_in        = a;
        b_in        = b;
        a_valid_in  = 1'b1;
        b_valid_in  = 1'b1;
        a_last_in   = last;
        signed_mode = sm;
        tick();
    endtask

    task automatic flush();
        idle();
        drain_shift    = 1'b1;
        drain_valid_in = 1'b0;
        tick();
        drain_shift    = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        en             = 1'b1;
        clear_acc      = 1'b0;
        signed_mode    = 1'b1;
        a_in           = '0;
        b_in           = '0;
        drain_in       = '0;
        drain_valid_in = 1'b0;
        drain_shift    = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        check("reset_acc", acc_out, 32'h0);
        check("reset_drain_valid", {31'b0, drain_valid_out}, 32'h0);
        check("reset_a_valid", {31'b0, a_valid_out}, 32'h0);
        check("reset_ovf_err", {30'b0, ovf, drain_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Signed dot product {3,-2,5}.{4,7,-1} = -7
        beat(16'd3, 16'd4, 1'b0, 1'b1);
        check("fwd_a_lag", {16'b0, a_out}, 32'd3);
        check("fwd_valids", {30'b0, a_valid_out, b_valid_out}, 32'h3);
        beat(16'hFFFE, 16'd7, 1'b0, 1'b1);
        beat(16'd5, 16'hFFFF, 1'b1, 1'b1);
        check("dot_partial_acc", acc_out, 32'hFFFF_FFFE);
        check("fwd_last", {31'b0, a_last_out}, 32'h1);
        idle();
        tick();
        check("dot_result", drain_out, 32'hFFFF_FFF9);
        check("dot_result_valid", {31'b0, drain_valid_out}, 32'h1);
        check("dot_auto_clear", acc_out, 32'h0);
        tick();
        check("dot_acc_stays_clear", acc_out, 32'h0);

        // Unsigned vs signed on 0xFFFF * 0x0002
        flush();
        beat(16'hFFFF, 16'h0002, 1'b1, 1'b0);
        idle();
        tick();
        check("unsigned_product", drain_out, 32'h0001_FFFE);
        flush();
        beat(16'hFFFF, 16'h0002, 1'b1, 1'b1);
        idle();
        tick();
        check("signed_product", drain_out, 32'hFFFF_FFFE);
        check("no_collision_err", {31'b0, drain_err}, 32'h0);

        // Saturation: 3 x 0x3FFF0001 overflows the signed range
        beat(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
        beat(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
        beat(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
        check("sat_pre_acc", acc_out, 32'h7FFE_0002);
        check("sat_pre_ovf", {31'b0, ovf}, 32'h0);
        idle();
        tick();
        check("sat_clamp", acc_out, 32'h7FFF_FFFF);
        check("sat_ovf", {31'b0, ovf}, 32'h1);
        clear_acc = 1'b1;
        tick();
        clear_acc = 1'b0;
        check("clear_acc", acc_out, 32'h0);
        check("clear_ovf", {31'b0, ovf}, 32'h0);

        // Back-to-back tiles: {1,1}.{1,1}=2 then {2,2}.{2,2}=8
        flush();
        beat(16'd1, 16'd1, 1'b0, 1'b1);
        beat(16'd1, 16'd1, 1'b1, 1'b1);
        beat(16'd2, 16'd2, 1'b0, 1'b1);
        check("b2b_tile1", drain_out, 32'd2);
        beat(16'd2, 16'd2, 1'b1, 1'b1);
        check("b2b_tile2_partial", acc_out, 32'd4);
        idle();
        drain_shift = 1'b1;
        tick();
        drain_shift = 1'b0;
        check("b2b_tile2", drain_out, 32'd8);
        check("b2b_no_err", {31'b0, drain_err}, 32'h0);
        check("b2b_acc_clear", acc_out, 32'h0);

        // Drain collision with valid upstream data
        beat(16'd5, 16'd1, 1'b1, 1'b1);
        idle();
        drain_shift    = 1'b1;
        drain_valid_in = 1'b1;
        drain_in       = 32'h0000_DEAD;
        tick();
        check("collide_capture_wins", drain_out, 32'd5);
        check("collide_err", {31'b0, drain_err}, 32'h1);
        drain_in = 32'h0000_1234;
        tick();
        drain_shift    = 1'b0;
        drain_valid_in = 1'b0;
        check("shift_in_data", drain_out, 32'h0000_1234);
        check("shift_in_valid", {31'b0, drain_valid_out}, 32'h1);
        check("err_sticky", {31'b0, drain_err}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("err_reset", {31'b0, drain_err}, 32'h0);

        // Capture with shift but no upstream valid: old result moves on, no error
        beat(16'd3, 16'd1, 1'b1, 1'b1);
        idle();
        tick();
        beat(16'd5, 16'd1, 1'b1, 1'b1);
        idle();
        drain_shift = 1'b1;
        tick();
        drain_shift = 1'b0;
        check("shift_capture", drain_out, 32'd5);
        check("shift_capture_no_err", {31'b0, drain_err}, 32'h0);

        // en=0 for 3 cycles mid-tile: {2,3}.{4,5} = 23
        flush();
        beat(16'd2, 16'd4, 1'b0, 1'b1);
        beat(16'd3, 16'd5, 1'b1, 1'b1);
        en = 1'b0;
        beat(16'h0055, 16'h0066, 1'b1, 1'b1);
        tick();
        tick();
        check("freeze_a_out", {16'b0, a_out}, 32'd3);
        check("freeze_b_out", {16'b0, b_out}, 32'd5);
        check("freeze_acc", acc_out, 32'd8);
        check("freeze_drain_valid", {31'b0, drain_valid_out}, 32'h0);
        en = 1'b1;
        idle();
        tick();
        check("freeze_result", drain_out, 32'd23);
        check("freeze_result_valid", {31'b0, drain_valid_out}, 32'h1);

        // Asynchronous reset mid-tile
        beat(16'd7, 16'd7, 1'b0, 1'b1);
        beat(16'd7, 16'd7, 1'b0, 1'b1);
        check("pre_reset_acc", acc_out, 32'd49);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a_out", {16'b0, a_out}, 32'h0);
        check("async_rst_acc", acc_out, 32'h0);
        check("async_rst_drain", drain_out, 32'h0);
        check("async_rst_flags", {28'b0, drain_valid_out, a_valid_out, b_valid_out, ovf}, 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        beat(16'd1, 16'd1, 1'b1, 1'b1);
        idle();
        tick();
        check("post_reset_clean", drain_out, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
